// File: rtl/id_hazard_ctrl_pkg.sv
// Shared pipeline types for the ID-stage hazard controller: register address
// width, stall-count encoding, FSM states and the shadow-stage record.
package id_hazard_ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef logic [1:0] stall_n_t;
   localparam stall_n_t STALL_NONE = 2'd0;
   localparam stall_n_t STALL_ONE  = 2'd1;
   localparam stall_n_t STALL_TWO  = 2'd2;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_e;

   typedef struct packed {
      logic      mem_read;
      logic      reg_write;
      reg_addr_t write_reg_addr;
   } shadow_t;

   localparam shadow_t SHADOW_CLEAR = '0;

endpackage

// File: rtl/id_hazard_ctrl_hazard_match.sv
// Combinational check of one shadow pipeline stage against the ID sources.
module hazard_match
   import id_hazard_ctrl_pkg::*;
(
   input  shadow_t                 stage,
   input  logic [REG_ADDR_W-1:0]   rs,
   input  logic [REG_ADDR_W-1:0]   rt,
   input  logic                    uses_rt,
   output logic                    match
);

   logic dest_live;

   // $0 is hardwired zero, so writes to it never create a dependence.
   assign dest_live = stage.reg_write && (stage.write_reg_addr != '0);

   assign match = dest_live &&
                  ((stage.write_reg_addr == rs) ||
                   (uses_rt && (stage.write_reg_addr == rt)));

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: load-use and branch-in-ID stalls, taken-branch
// squash of IF/ID, and a saturating stall performance counter.
module id_hazard_ctrl
   import id_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] if_id_instr_rs,
   input  logic [REG_ADDR_W-1:0] if_id_instr_rt,
   input  logic                  id_uses_rt,
   input  logic                  id_branch,
   input  logic                  id_branch_taken,
   input  logic                  id_mem_read,
   input  logic                  id_reg_write,
   input  logic [REG_ADDR_W-1:0] id_write_reg_addr,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_bubble,
   output logic                  if_id_flush,
   output logic [CNT_W-1:0]      stall_count
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_e   state, state_nxt;
   stall_n_t remaining, remaining_nxt;
   stall_n_t n_req;
   shadow_t  idex_shd_p1, exmem_shd_p2;
   logic     idex_match, exmem_match;

   hazard_match u_idex_match (
      .stage   (idex_shd_p1),
      .rs      (if_id_instr_rs),
      .rt      (if_id_instr_rt),
      .uses_rt (id_uses_rt),
      .match   (idex_match)
   );

   hazard_match u_exmem_match (
      .stage   (exmem_shd_p2),
      .rs      (if_id_instr_rs),
      .rt      (if_id_instr_rt),
      .uses_rt (id_uses_rt),
      .match   (exmem_match)
   );

   // Later assignments only ever raise n, so the result is the maximum rule.
   always_comb begin
      n_req = STALL_NONE;
      if (idex_match && idex_shd_p1.mem_read) n_req = STALL_ONE;
      if (id_branch) begin
         if (exmem_match && exmem_shd_p2.mem_read) n_req = STALL_ONE;
         if (idex_match) n_req = idex_shd_p1.mem_read ? STALL_TWO : STALL_ONE;
      end
   end

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_bubble  = 1'b0;
      if_id_flush   = 1'b0;
      case (state)
         RUN: begin
            if (n_req != STALL_NONE) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
               if (n_req == STALL_TWO) begin
                  state_nxt     = STALL;
                  remaining_nxt = n_req - STALL_ONE;
               end else begin
                  remaining_nxt = STALL_NONE;
               end
            end else begin
               if_id_flush = id_branch && id_branch_taken;
            end
         end
         STALL: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (remaining <= STALL_ONE) begin
               state_nxt     = RUN;
               remaining_nxt = STALL_NONE;
            end else begin
               remaining_nxt = remaining - STALL_ONE;
            end
         end
         default: begin
            state_nxt     = RUN;
            remaining_nxt = STALL_NONE;
         end
      endcase
   end

   // Shadow stages advance every cycle; a bubble enters ID/EX as all-zero control.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RUN;
         remaining    <= STALL_NONE;
         idex_shd_p1  <= SHADOW_CLEAR;
         exmem_shd_p2 <= SHADOW_CLEAR;
         stall_count  <= '0;
      end else begin
         state        <= state_nxt;
         remaining    <= remaining_nxt;
         exmem_shd_p2 <= idex_shd_p1;
         if (id_ex_bubble) begin
            idex_shd_p1 <= SHADOW_CLEAR;
            stall_count <= sat_inc(stall_count);
         end else begin
            idex_shd_p1 <= '{mem_read:       id_mem_read,
                             reg_write:      id_reg_write,
                             write_reg_addr: id_write_reg_addr};
         end
      end
   end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed hazard scenarios plus randomized traffic
// checked against a cycle-level reference model of the stall rules.
module tb_id_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [4:0] rs, rt, wra;
   logic       uses_rt, branch, taken, mem_read, reg_write;

   logic        pc_write, if_id_write, id_ex_bubble, if_id_flush;
   logic [15:0] stall_count;
   logic        pc_write4, if_id_write4, id_ex_bubble4, if_id_flush4;
   logic [3:0]  stall_count4;

   int checks = 0;
   int fails  = 0;

   id_hazard_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .if_id_instr_rs(rs), .if_id_instr_rt(rt), .id_uses_rt(uses_rt),
      .id_branch(branch), .id_branch_taken(taken), .id_mem_read(mem_read),
      .id_reg_write(reg_write), .id_write_reg_addr(wra),
      .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
      .if_id_flush(if_id_flush), .stall_count(stall_count)
   );

   id_hazard_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset),
      .if_id_instr_rs(rs), .if_id_instr_rt(rt), .id_uses_rt(uses_rt),
      .id_branch(branch), .id_branch_taken(taken), .id_mem_read(mem_read),
      .id_reg_write(reg_write), .id_write_reg_addr(wra),
      .pc_write(pc_write4), .if_id_write(if_id_write4), .id_ex_bubble(id_ex_bubble4),
      .if_id_flush(if_id_flush4), .stall_count(stall_count4)
   );

   // Reference model: the two instructions issued ahead of ID, plus the number
   // of stall cycles still owed from an earlier decision.
   typedef struct {bit mr; bit rw; int unsigned a;} ins_t;
   ins_t        m_idex, m_exmem;
   int          m_left;
   int unsigned m_cnt;
   bit          e_stall, e_flush;
   int          e_n;

   function automatic bit hit(ins_t s);
      return s.rw && (s.a != 0) && ((s.a == rs) || (uses_rt && (s.a == rt)));
   endfunction

   function automatic int rule_n();
      int n = 0;
      if (hit(m_idex) && m_idex.mr) n = 1;
      if (branch) begin
         if (hit(m_idex)) n = (m_idex.mr) ? 2 : ((n > 1) ? n : 1);
         if (hit(m_exmem) && m_exmem.mr && n < 1) n = 1;
      end
      return n;
   endfunction

   task automatic model_eval();
      if (m_left > 0) begin
         e_stall = 1'b1;
         e_n     = 0;
      end else begin
         e_n     = rule_n();
         e_stall = (e_n > 0);
      end
      e_flush = !e_stall && branch && taken;
   endtask

   task automatic step();
      model_eval();
      if (reset) begin
         m_idex  = '{1'b0, 1'b0, 0};
         m_exmem = '{1'b0, 1'b0, 0};
         m_left  = 0;
         m_cnt   = 0;
      end else begin
         if (m_left > 0) m_left--;
         else if (e_n > 0) m_left = e_n - 1;
         m_exmem = m_idex;
         if (e_stall) begin
            m_idex = '{1'b0, 1'b0, 0};
            m_cnt++;
         end else begin
            m_idex = '{mem_read, reg_write, int'(wra)};
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_id(input logic [4:0] r_s, input logic [4:0] r_t, input bit ur,
                         input bit br, input bit tk, input bit mr, input bit rw,
                         input logic [4:0] wa);
      rs = r_s; rt = r_t; uses_rt = ur; branch = br; taken = tk;
      mem_read = mr; reg_write = rw; wra = wa;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks++;
      if (pc_write !== 1'b1 || if_id_write !== 1'b1 || id_ex_bubble !== 1'b0 || if_id_flush !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs pc=%b ifid=%b bub=%b flush=%b required 1 1 0 0",
                  pc_write, if_id_write, id_ex_bubble, if_id_flush);
      end
      checks++;
      if (stall_count !== 16'd0 || stall_count4 !== 4'd0) begin
         fails++;
         $display("FAIL reset_count got %0d/%0d required 0/0", stall_count, stall_count4);
      end
   endtask

   task automatic test_load_use();
      apply_reset();
      set_id(1, 2, 0, 0, 0, 1, 1, 5);          // lw $5
      step();
      set_id(5, 6, 1, 0, 0, 0, 1, 8);          // add $8, $5, $6
      #1;
      checks++;
      if (pc_write !== 1'b0 || if_id_write !== 1'b0 || id_ex_bubble !== 1'b1 || if_id_flush !== 1'b0) begin
         fails++;
         $display("FAIL load_use_stall pc=%b ifid=%b bub=%b flush=%b required 0 0 1 0",
                  pc_write, if_id_write, id_ex_bubble, if_id_flush);
      end
      step();
      #1;
      checks++;
      if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0 || stall_count !== 16'd1) begin
         fails++;
         $display("FAIL load_use_resume pc=%b bub=%b cnt=%0d required 1 0 1",
                  pc_write, id_ex_bubble, stall_count);
      end
   endtask

   task automatic test_branch_load();
      apply_reset();
      set_id(1, 2, 0, 0, 0, 1, 1, 7);          // lw $7
      step();
      set_id(7, 9, 1, 1, 1, 0, 0, 0);          // beq $7, $9 taken
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (pc_write !== 1'b0 || id_ex_bubble !== 1'b1 || if_id_flush !== 1'b0) begin
            fails++;
            $display("FAIL branch_load_stall%0d pc=%b bub=%b flush=%b required 0 1 0",
                     c, pc_write, id_ex_bubble, if_id_flush);
         end
         step();
      end
      #1;
      checks++;
      if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0 || if_id_flush !== 1'b1 || stall_count !== 16'd2) begin
         fails++;
         $display("FAIL branch_load_resume pc=%b bub=%b flush=%b cnt=%0d required 1 0 1 2",
                  pc_write, id_ex_bubble, if_id_flush, stall_count);
      end
   endtask

   task automatic test_branch_alu();
      apply_reset();
      set_id(1, 2, 1, 0, 0, 0, 1, 3);          // add $3
      step();
      set_id(4, 3, 1, 1, 1, 0, 0, 0);          // beq $4, $3 taken
      #1;
      checks++;
      if (pc_write !== 1'b0 || id_ex_bubble !== 1'b1 || if_id_flush !== 1'b0) begin
         fails++;
         $display("FAIL branch_alu_stall pc=%b bub=%b flush=%b required 0 1 0",
                  pc_write, id_ex_bubble, if_id_flush);
      end
      step();
      #1;
      checks++;
      if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0 || if_id_flush !== 1'b1 || stall_count !== 16'd1) begin
         fails++;
         $display("FAIL branch_alu_resume pc=%b bub=%b flush=%b cnt=%0d required 1 0 1 1",
                  pc_write, id_ex_bubble, if_id_flush, stall_count);
      end
   endtask

   task automatic test_reg_zero();
      apply_reset();
      set_id(1, 2, 0, 0, 0, 1, 1, 0);          // lw $0
      step();
      set_id(0, 0, 1, 1, 0, 0, 0, 0);          // branch reading $0
      #1;
      checks++;
      if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
         fails++;
         $display("FAIL reg_zero pc=%b bub=%b required 1 0", pc_write, id_ex_bubble);
      end
      step();
      set_id(1, 2, 0, 0, 0, 1, 1, 6);          // lw $6
      step();
      set_id(1, 6, 0, 0, 0, 0, 1, 9);          // rt=6 but rt not a source
      #1;
      checks++;
      if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0 || stall_count !== 16'd0) begin
         fails++;
         $display("FAIL rt_unused pc=%b bub=%b cnt=%0d required 1 0 0",
                  pc_write, id_ex_bubble, stall_count);
      end
   endtask

   task automatic test_reset_mid_stall();
      apply_reset();
      set_id(1, 2, 0, 0, 0, 1, 1, 7);
      step();
      set_id(7, 9, 1, 1, 1, 0, 0, 0);
      step();
      #1;
      checks++;
      if (id_ex_bubble !== 1'b1 || pc_write !== 1'b0) begin
         fails++;
         $display("FAIL mid_stall_second pc=%b bub=%b required 0 1", pc_write, id_ex_bubble);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      checks++;
      if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0 || stall_count !== 16'd0) begin
         fails++;
         $display("FAIL mid_stall_reset pc=%b bub=%b cnt=%0d required 1 0 0",
                  pc_write, id_ex_bubble, stall_count);
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      set_id(5, 0, 0, 0, 0, 1, 1, 5);          // lw $5, 0($5) repeated: stall every other cycle
      for (int c = 0; c < 40; c++) step();
      #1;
      checks++;
      if (stall_count4 !== 4'd15 || stall_count !== 16'd20) begin
         fails++;
         $display("FAIL saturation cnt4=%0d cnt16=%0d required 15 20", stall_count4, stall_count);
      end
   endtask

   task automatic test_random();
      int unsigned exp16, exp4;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 59) == 0);
         set_id($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3));
         #1;
         model_eval();
         exp16 = (m_cnt > 65535) ? 65535 : m_cnt;
         exp4  = (m_cnt > 15) ? 15 : m_cnt;
         checks++;
         if (pc_write !== !e_stall || if_id_write !== !e_stall || id_ex_bubble !== e_stall ||
             if_id_flush !== e_flush) begin
            fails++;
            $display("FAIL random_ctrl cyc%0d pc=%b ifid=%b bub=%b flush=%b required stall=%b flush=%b",
                     c, pc_write, if_id_write, id_ex_bubble, if_id_flush, e_stall, e_flush);
         end
         checks++;
         if (pc_write4 !== !e_stall || id_ex_bubble4 !== e_stall || if_id_flush4 !== e_flush ||
             if_id_write4 !== !e_stall) begin
            fails++;
            $display("FAIL random_ctrl4 cyc%0d pc=%b bub=%b flush=%b required stall=%b flush=%b",
                     c, pc_write4, id_ex_bubble4, if_id_flush4, e_stall, e_flush);
         end
         checks++;
         if (stall_count !== exp16[15:0] || stall_count4 !== exp4[3:0]) begin
            fails++;
            $display("FAIL random_count cyc%0d got %0d/%0d required %0d/%0d",
                     c, stall_count, stall_count4, exp16, exp4);
         end
         step();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      m_idex = '{1'b0, 1'b0, 0};
      m_exmem = '{1'b0, 1'b0, 0};
      m_left = 0;
      m_cnt = 0;
      @(negedge clk);
      test_reset();
      test_load_use();
      test_branch_load();
      test_branch_alu();
      test_reg_zero();
      test_reset_mid_stall();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
